// File: rtl/coffee_brew_seq.sv
// ============================================================================
// coffee_brew_seq
// ----------------------------------------------------------------------------
// Brew sequencer sitting after the coffee selection FSM. A one-cycle drink
// select pulse starts a recipe; the sequencer then steps through timed phases
// (grind, water, milk, foam) and drives one actuator per phase. busy is high
// for the whole drink and done pulses for one cycle when the cup is finished.
//
// Parameters:
//   GRIND_CYC, WATER_CYC, MILK_CYC, FOAM_CYC : phase lengths in clk cycles (>=1)
//   CNT_W                                   : phase timer width
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous, active-high reset
//   start_expr   in   one-cycle pulse: brew espresso
//   start_latte  in   one-cycle pulse: brew latte
//   start_capp   in   one-cycle pulse: brew cappuccino
//   abort        in   level: cancel the drink in progress
//   grinder      out  grinder motor enable
//   water_valve  out  hot-water valve enable
//   milk_pump    out  milk pump enable
//   foamer       out  steam/foam enable
//   busy         out  high whenever the sequencer is not idle
//   done         out  one-cycle pulse, drink complete
//   cup_cnt      out  completed-drink count
//
// Configuration macro:
//   COFFEE_CUP_CNT_EN  defined   : cup_cnt counts done pulses, saturating at 8'hFF
//                      undefined : cup_cnt is tied to 8'h00
// ============================================================================
module coffee_brew_seq #(
  parameter int GRIND_CYC = 4,
  parameter int WATER_CYC = 6,
  parameter int MILK_CYC  = 5,
  parameter int FOAM_CYC  = 3,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_expr,
  input  logic       start_latte,
  input  logic       start_capp,
  input  logic       abort,
  output logic       grinder,
  output logic       water_valve,
  output logic       milk_pump,
  output logic       foamer,
  output logic       busy,
  output logic       done,
  output logic [7:0] cup_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRIND = 3'd1,
    WATER = 3'd2,
    MILK  = 3'd3,
    FOAM  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [1:0] REC_NONE  = 2'd0;
  localparam logic [1:0] REC_EXPR  = 2'd1;
  localparam logic [1:0] REC_LATTE = 2'd2;
  localparam logic [1:0] REC_CAPP  = 2'd3;

  localparam logic [CNT_W-1:0] GRIND_LAST = CNT_W'(GRIND_CYC - 1);
  localparam logic [CNT_W-1:0] WATER_LAST = CNT_W'(WATER_CYC - 1);
  localparam logic [CNT_W-1:0] MILK_LAST  = CNT_W'(MILK_CYC - 1);
  localparam logic [CNT_W-1:0] FOAM_LAST  = CNT_W'(FOAM_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nxt;
  logic [1:0]       recipe;
  logic [1:0]       recipe_nxt;

  // Next-state logic. The timer runs freely inside a phase and is cleared
  // whenever the state changes, so a phase lasts exactly <PHASE>_CYC cycles.
  // abort is checked before the phase-end test so it always wins, and only
  // the four actuator phases look at it; IDLE and DONE ignore it.
  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer + CNT_W'(1);
    recipe_nxt = recipe;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (start_capp) begin
          state_nxt  = GRIND;
          recipe_nxt = REC_CAPP;
        end else if (start_latte) begin
          state_nxt  = GRIND;
          recipe_nxt = REC_LATTE;
        end else if (start_expr) begin
          state_nxt  = GRIND;
          recipe_nxt = REC_EXPR;
        end
      end
      GRIND: begin
        if (abort) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (timer == GRIND_LAST) begin
          state_nxt = WATER;
          timer_nxt = '0;
        end
      end
      WATER: begin
        if (abort) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (timer == WATER_LAST) begin
          state_nxt = (recipe == REC_EXPR) ? DONE : MILK;
          timer_nxt = '0;
        end
      end
      MILK: begin
        if (abort) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (timer == MILK_LAST) begin
          state_nxt = (recipe == REC_LATTE) ? DONE : FOAM;
          timer_nxt = '0;
        end
      end
      FOAM: begin
        if (abort) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (timer == FOAM_LAST) begin
          state_nxt = DONE;
          timer_nxt = '0;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
      default: begin
        state_nxt  = IDLE;
        timer_nxt  = '0;
        recipe_nxt = REC_NONE;
      end
    endcase
  end

  // State, timer and recipe registers. The outputs are registered alongside
  // them by decoding the next state, so each output is a pure function of the
  // state register with no combinational path from any input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      recipe      <= REC_NONE;
      grinder     <= 1'b0;
      water_valve <= 1'b0;
      milk_pump   <= 1'b0;
      foamer      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      recipe      <= recipe_nxt;
      grinder     <= (state_nxt == GRIND);
      water_valve <= (state_nxt == WATER);
      milk_pump   <= (state_nxt == MILK);
      foamer      <= (state_nxt == FOAM);
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
    end
  end

`ifdef COFFEE_CUP_CNT_EN
  logic [7:0] cup_cnt_q;

  // Completed-cup counter, stepped by the done pulse and held at 8'hFF once
  // full rather than wrapping back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cup_cnt_q <= 8'h00;
    end else if (done && (cup_cnt_q != 8'hFF)) begin
      cup_cnt_q <= cup_cnt_q + 8'h01;
    end
  end

  assign cup_cnt = cup_cnt_q;
`else
  assign cup_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_coffee_brew_seq.sv
// ============================================================================
// tb_coffee_brew_seq
// ----------------------------------------------------------------------------
// Self-checking bench for coffee_brew_seq with default parameters. The
// reference model is a queue of expected per-cycle output words: an accepted
// start appends the whole recipe schedule (one entry per cycle), every cycle
// pops one entry, and an abort during an actuator phase empties the queue.
// An empty queue means idle. Output word bits:
//   [5] grinder [4] water_valve [3] milk_pump [2] foamer [1] busy [0] done
// ============================================================================
module tb_coffee_brew_seq;

  localparam int GRIND_CYC = 4;
  localparam int WATER_CYC = 6;
  localparam int MILK_CYC  = 5;
  localparam int FOAM_CYC  = 3;

  localparam logic [7:0] W_GRIND = 8'h22;
  localparam logic [7:0] W_WATER = 8'h12;
  localparam logic [7:0] W_MILK  = 8'h0A;
  localparam logic [7:0] W_FOAM  = 8'h06;
  localparam logic [7:0] W_DONE  = 8'h03;

  logic       clk;
  logic       rst;
  logic       start_expr;
  logic       start_latte;
  logic       start_capp;
  logic       abort;
  logic       grinder;
  logic       water_valve;
  logic       milk_pump;
  logic       foamer;
  logic       busy;
  logic       done;
  logic [7:0] cup_cnt;

  int         checks;
  int         errors;
  logic [7:0] exp_q[$];
  int         model_cups;
  int         done_at;

  coffee_brew_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start_expr  (start_expr),
    .start_latte (start_latte),
    .start_capp  (start_capp),
    .abort       (abort),
    .grinder     (grinder),
    .water_valve (water_valve),
    .milk_pump   (milk_pump),
    .foamer      (foamer),
    .busy        (busy),
    .done        (done),
    .cup_cnt     (cup_cnt)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h at time %0t",
               tag, observed, expected, $time);
    end
  endtask

  function automatic logic [7:0] expCups();
`ifdef COFFEE_CUP_CNT_EN
    return 8'(model_cups);
`else
    return 8'h00;
`endif
  endfunction

  // Append the full per-cycle schedule of one drink to the model queue.
  task automatic pushRecipe(input int kind);
    for (int i = 0; i < GRIND_CYC; i++) exp_q.push_back(W_GRIND);
    for (int i = 0; i < WATER_CYC; i++) exp_q.push_back(W_WATER);
    if (kind >= 2) for (int i = 0; i < MILK_CYC; i++) exp_q.push_back(W_MILK);
    if (kind == 3) for (int i = 0; i < FOAM_CYC; i++) exp_q.push_back(W_FOAM);
    exp_q.push_back(W_DONE);
  endtask

  // One cycle: check the current outputs against the model, drive this
  // cycle's inputs, advance the model, then move to just after the next edge.
  task automatic applyStimulus(input logic se, input logic sl, input logic sc,
                               input logic ab);
    logic [7:0] cur;
    logic [7:0] popped;
    cur = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    checkOutput("outputs", {2'b00, grinder, water_valve, milk_pump, foamer, busy, done}, cur);
    checkOutput("cup_cnt", cup_cnt, expCups());
    start_expr  = se;
    start_latte = sl;
    start_capp  = sc;
    abort       = ab;
    if (exp_q.size() > 0) begin
      popped = exp_q.pop_front();
      if (popped[0]) begin
        if (model_cups < 255) model_cups++;
      end else if (ab) begin
        exp_q.delete();
      end
    end else if (sc) begin
      pushRecipe(3);
    end else if (sl) begin
      pushRecipe(2);
    end else if (se) begin
      pushRecipe(1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst         = 1'b1;
    start_expr  = 1'b0;
    start_latte = 1'b0;
    start_capp  = 1'b0;
    abort       = 1'b0;
    exp_q.delete();
    model_cups = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {2'b00, grinder, water_valve, milk_pump, foamer, busy, done}, 8'h00);
    checkOutput("reset_cup_cnt", cup_cnt, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    doReset();

    // Espresso, with an explicit check of the done cycle.
    done_at = -1;
    applyStimulus(1, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      if (done && done_at < 0) done_at = i;
      applyStimulus(0, 0, 0, 0);
    end
    checkOutput("expr_done_cycle", 8'(done_at), 8'd11);

    // Latte.
    applyStimulus(0, 1, 0, 0);
    repeat (17) applyStimulus(0, 0, 0, 0);

    // Cappuccino with simultaneous espresso start: cappuccino wins.
    done_at = -1;
    applyStimulus(1, 0, 1, 0);
    for (int i = 1; i <= 20; i++) begin
      if (done && done_at < 0) done_at = i;
      applyStimulus(0, 0, 0, 0);
    end
    checkOutput("capp_done_cycle", 8'(done_at), 8'd19);

    // Espresso aborted in cycle 7.
    applyStimulus(1, 0, 0, 0);
    repeat (6) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("abort_busy", {7'd0, busy}, 8'h00);
    repeat (3) applyStimulus(0, 0, 0, 0);

    // Latte start in cycle 3 during espresso is ignored; cycle 12 start accepted.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    repeat (8) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    repeat (22) applyStimulus(0, 0, 0, 0);

    // Abort in IDLE and during DONE has no effect.
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0);
    repeat (10) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    repeat (2) applyStimulus(0, 0, 0, 0);

    // Randomized pulses and aborts.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0));
    end
    repeat (25) applyStimulus(0, 0, 0, 0);

    // Asynchronous reset in the middle of WATER clears outputs without an edge.
    applyStimulus(1, 0, 0, 0);
    repeat (6) applyStimulus(0, 0, 0, 0);
    checkOutput("pre_rst_water", {7'd0, water_valve}, 8'h01);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_outputs", {2'b00, grinder, water_valve, milk_pump, foamer, busy, done}, 8'h00);
    checkOutput("async_rst_cup_cnt", cup_cnt, 8'h00);
    exp_q.delete();
    model_cups = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Long run of espressos: the counter saturates at 8'hFF when enabled.
    for (int n = 0; n < 260; n++) begin
      applyStimulus(1, 0, 0, 0);
      repeat (11) applyStimulus(0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0);
`ifdef COFFEE_CUP_CNT_EN
    checkOutput("cup_cnt_saturate", cup_cnt, 8'hFF);
`else
    checkOutput("cup_cnt_tied", cup_cnt, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
